arbitro_polinomio: RTL and testbench

//  Round-robin arbiter/sequencer sharing one polynomial core (ports inicio/X/A/B/C in, Resultado/pronto/overflow out) among N_REQ requesters.

---
 rtl/arbitro_polinomio_pkg.sv | 21 ++
 rtl/rr_prioridade.sv | 34 +++
 rtl/arbitro_polinomio.sv | 133 +++++++++++++
 tb/tb_arbitro_polinomio.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_polinomio_pkg.sv
// Shared definitions for the polynomial-core arbiter: FSM states,
// default sizing and a small helper for index/counter widths.
package arbitro_polinomio_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DISPARA = 2'd1,
        AGUARDA = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    localparam int unsigned N_REQ_PADRAO   = 4;
    localparam int unsigned W_PADRAO       = 16;
    localparam int unsigned TIMEOUT_PADRAO = 64;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned largura_indice(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prioridade.sv
// Combinational round-robin picker: returns the first requester at or
// after ponteiro+1 (wrapping), as a one-hot vector plus its index.
module rr_prioridade
    import arbitro_polinomio_pkg::*;
#(
    parameter int unsigned N  = N_REQ_PADRAO,
    parameter int unsigned IW = largura_indice(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ponteiro,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] indice,
    output logic          valido
);

    logic [IW-1:0] j;

    // Scan N positions starting just past the last served requester.
    always_comb begin
        grant  = '0;
        indice = '0;
        valido = 1'b0;
        j      = '0;
        for (int unsigned d = 1; d <= N; d++) begin
            j = IW'((32'(ponteiro) + d) % N);
            if (!valido && req[j]) begin
                grant[j] = 1'b1;
                indice   = j;
                valido   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_polinomio.sv
// Round-robin sequencer sharing one polynomial core among N_REQ clients:
// grants a requester, latches its operands, pulses the core start, waits
// (with timeout) for the core and hands the result back to that client.
module arbitro_polinomio
    import arbitro_polinomio_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_PADRAO,
    parameter int unsigned W       = W_PADRAO,
    parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic               ck,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_c,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       resultado,
    output logic               overflow,
    output logic               erro,
    output logic               core_inicio,
    output logic [W-1:0]       core_x,
    output logic [W-1:0]       core_a,
    output logic [W-1:0]       core_b,
    output logic [W-1:0]       core_c,
    input  logic [W-1:0]       core_resultado,
    input  logic               core_pronto,
    input  logic               core_overflow
);

    localparam int unsigned IW = largura_indice(N_REQ);
    localparam int unsigned CW = largura_indice(TIMEOUT);

    estado_t                  estado;
    logic [IW-1:0]            ponteiro;
    logic [IW-1:0]            idx_atual;
    logic [CW-1:0]            contador;

    logic [N_REQ-1:0]         escolha_oh;
    logic [IW-1:0]            escolha_idx;
    logic                     escolha_ok;

    logic [N_REQ-1:0][W-1:0]  vet_x;
    logic [N_REQ-1:0][W-1:0]  vet_a;
    logic [N_REQ-1:0][W-1:0]  vet_b;
    logic [N_REQ-1:0][W-1:0]  vet_c;

    assign vet_x = req_x;
    assign vet_a = req_a;
    assign vet_b = req_b;
    assign vet_c = req_c;

    rr_prioridade #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req      (req),
        .ponteiro (ponteiro),
        .grant    (escolha_oh),
        .indice   (escolha_idx),
        .valido   (escolha_ok)
    );

    // Sequencer FSM with registered grant/done/start, operand and result latches.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            estado      <= OCIOSO;
            ponteiro    <= IW'(N_REQ - 1);
            idx_atual   <= '0;
            contador    <= '0;
            gnt         <= '0;
            done        <= '0;
            resultado   <= '0;
            overflow    <= 1'b0;
            erro        <= 1'b0;
            core_inicio <= 1'b0;
            core_x      <= '0;
            core_a      <= '0;
            core_b      <= '0;
            core_c      <= '0;
        end else begin
            core_inicio <= 1'b0;
            done        <= '0;
            case (estado)
                OCIOSO: begin
                    if (escolha_ok) begin
                        core_x      <= vet_x[escolha_idx];
                        core_a      <= vet_a[escolha_idx];
                        core_b      <= vet_b[escolha_idx];
                        core_c      <= vet_c[escolha_idx];
                        gnt         <= escolha_oh;
                        idx_atual   <= escolha_idx;
                        // registered so the pulse coincides with the DISPARA cycle
                        core_inicio <= 1'b1;
                        estado      <= DISPARA;
                    end
                end
                DISPARA: begin
                    contador <= '0;
                    estado   <= AGUARDA;
                end
                AGUARDA: begin
                    // contador==0 is the first waiting cycle: a pronto left
                    // over from the previous job is ignored there
                    if ((contador != '0) && core_pronto) begin
                        resultado <= core_resultado;
                        overflow  <= core_overflow;
                        erro      <= 1'b0;
                        done      <= gnt;
                        estado    <= ENTREGA;
                    end else if (contador == CW'(TIMEOUT - 1)) begin
                        resultado <= '0;
                        overflow  <= 1'b0;
                        erro      <= 1'b1;
                        done      <= gnt;
                        estado    <= ENTREGA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                ENTREGA: begin
                    gnt      <= '0;
                    ponteiro <= idx_atual;
                    estado   <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_polinomio.sv
// Directed bench for arbitro_polinomio with a behavioural polynomial core
// (R = A*X*X + B*X + C, pronto 10 cycles after inicio).
module tb_arbitro_polinomio;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 64;
    localparam int LAT = 12;

    logic             ck  = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_x = '0, req_a = '0, req_b = '0, req_c = '0;
    logic [N-1:0]     gnt, done;
    logic [W-1:0]     resultado;
    logic             overflow, erro, core_inicio;
    logic [W-1:0]     core_x, core_a, core_b, core_c;
    logic [W-1:0]     core_resultado;
    logic             core_pronto, core_overflow;

    arbitro_polinomio #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
        .ck(ck), .rst(rst), .req(req),
        .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .gnt(gnt), .done(done), .resultado(resultado), .overflow(overflow),
        .erro(erro), .core_inicio(core_inicio),
        .core_x(core_x), .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .core_resultado(core_resultado), .core_pronto(core_pronto),
        .core_overflow(core_overflow)
    );

    always #5 ck = ~ck;

    // behavioural core
    logic [W-1:0] m_res = '0, pend_res = '0;
    logic         m_ovf = 1'b0, pend_ovf = 1'b0, m_pronto = 1'b0;
    int           m_cnt = 0;
    bit           never_pronto = 1'b0;
    bit           hold_pronto  = 1'b0;
    longint unsigned v;

    assign core_resultado = m_res;
    assign core_overflow  = m_ovf;
    assign core_pronto    = m_pronto;

    always @(posedge ck) begin
        if (core_inicio) begin
            v = longint'(core_a) * core_x * core_x + longint'(core_b) * core_x + core_c;
            pend_res <= v[W-1:0];
            pend_ovf <= (v > 64'hFFFF);
            m_cnt    <= 10;
            if (!hold_pronto) m_pronto <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 10) m_pronto <= 1'b0;
            if (m_cnt == 1 && !never_pronto) begin
                m_pronto <= 1'b1;
                m_res    <= pend_res;
                m_ovf    <= pend_ovf;
            end
        end else if (!hold_pronto) begin
            m_pronto <= 1'b0;
        end
    end

    // global monitors
    int n_inicio = 0;
    int sobrep   = 0;
    always @(posedge ck) begin
        if (core_inicio) n_inicio++;
        if ($countones(done) > 1 || $countones(gnt) > 1) sobrep++;
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nome, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        d = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge ck);
            if (done != '0) begin
                d = done;
                break;
            end
        end
    endtask

    // One job on a single requester; req dropped and operands scrambled one cycle after grant.
    task automatic run_single(input int idx, input logic [W-1:0] x, a, b, c, r,
                              input logic ov, input logic er, input int lat, input string nome);
        int t0 = -1, gc = -1, nini = 0, lm = -1;
        @(negedge ck);
        req_x[idx*W +: W] = x;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_c[idx*W +: W] = c;
        req[idx] = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge ck);
            if (core_inicio) begin
                nini++;
                if (t0 < 0) t0 = k;
            end
            if (done != '0) begin
                if (t0 >= 0) lm = k - t0;
                break;
            end
            if (gnt != '0 && gc < 0) gc = k;
            else if (gc >= 0 && k == gc + 1) begin
                req[idx] = 1'b0;
                req_x[idx*W +: W] = ~x;
                req_a[idx*W +: W] = ~a;
                req_b[idx*W +: W] = ~b;
                req_c[idx*W +: W] = ~c;
            end
        end
        chk({nome, "/done"}, done, 1 << idx);
        chk({nome, "/gnt"}, gnt, 1 << idx);
        chk({nome, "/resultado"}, resultado, r);
        chk({nome, "/overflow"}, overflow, ov);
        chk({nome, "/erro"}, erro, er);
        chk({nome, "/core_x"}, core_x, x);
        chk({nome, "/core_c"}, core_c, c);
        chk({nome, "/inicio_count"}, nini, 1);
        chk({nome, "/latency"}, lm, lat);
        req[idx] = 1'b0;
    endtask

    typedef struct {
        int         idx;
        logic [W-1:0] x, a, b, c, r;
        logic       ov;
    } vec_t;

    vec_t tab[6];
    logic [W-1:0] exp2[4];
    logic [N-1:0] d;
    int base;

    initial begin
        tab[0] = '{0, 16'd23,  16'd38,   16'd333,  16'd4902,  16'd32663, 1'b0};
        tab[1] = '{1, 16'd300, 16'd1,    16'd0,    16'd0,     16'd24464, 1'b1};
        tab[2] = '{2, 16'd0,   16'hFFFF, 16'hFFFF, 16'h1234,  16'h1234,  1'b0};
        tab[3] = '{1, 16'd10,  16'd100,  16'd10,   16'd1,     16'd10101, 1'b0};
        tab[4] = '{2, 16'd1,   16'd1,    16'd1,    16'd65534, 16'd0,     1'b1};
        tab[5] = '{3, 16'd1,   16'd1,    16'd1,    16'd65533, 16'd65535, 1'b0};
        exp2 = '{16'd2, 16'd108, 16'd224, 16'd356};

        // reset state
        #1 rst = 1'b0;
        repeat (3) @(negedge ck);
        chk("rst/gnt", gnt, 0);
        chk("rst/done", done, 0);
        chk("rst/resultado", resultado, 0);
        chk("rst/erro", erro, 0);
        chk("rst/core_inicio", core_inicio, 0);
        chk("rst/core_x", core_x, 0);
        rst = 1'b1;

        // single-requester table (first entry is the reference job)
        for (int k = 0; k < 6; k++) begin
            run_single(tab[k].idx, tab[k].x, tab[k].a, tab[k].b, tab[k].c,
                       tab[k].r, tab[k].ov, 1'b0, LAT, $sformatf("vec%0d", k));
            if (k == 0) begin
                repeat (3) @(negedge ck);
                chk("hold/resultado", resultado, 16'd32663);
                chk("hold/done", done, 0);
            end
        end

        // all four pending: strict rotation 0,1,2,3,0,1,2,3
        @(negedge ck);
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = 16'(i + 1);
            req_a[i*W +: W] = 16'(i);
            req_b[i*W +: W] = 16'd2;
            req_c[i*W +: W] = 16'(100 * i);
        end
        base = n_inicio;
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            wait_done(d);
            chk($sformatf("rr%0d/done", j), d, 1 << (j % 4));
            chk($sformatf("rr%0d/resultado", j), resultado, exp2[j % 4]);
            if (j == 7) req = '0;
        end
        repeat (5) @(negedge ck);
        chk("rr/inicio_count", n_inicio - base, 8);
        chk("rr/overlap", sobrep, 0);

        // timeout, then a normal job
        never_pronto = 1'b1;
        run_single(1, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1, TMO + 1, "timeout");
        never_pronto = 1'b0;
        run_single(2, 16'd2, 16'd3, 16'd5, 16'd7, 16'd29, 1'b0, 1'b0, LAT, "after_tmo");

        // asynchronous reset while waiting on the core
        @(negedge ck);
        req_x[0 +: W] = 16'd5; req_a[0 +: W] = 16'd1;
        req_b[0 +: W] = 16'd1; req_c[0 +: W] = 16'd1;
        req = 4'b0001;
        begin : espera_inicio
            bit visto = 1'b0;
            for (int k = 0; k < 20 && !visto; k++) begin
                @(negedge ck);
                if (core_inicio) visto = 1'b1;
            end
            chk("arst/inicio_seen", visto, 1);
        end
        @(negedge ck);
        #2 rst = 1'b0;
        #1;
        chk("arst/gnt", gnt, 0);
        chk("arst/done", done, 0);
        chk("arst/resultado", resultado, 0);
        chk("arst/overflow", overflow, 0);
        chk("arst/erro", erro, 0);
        chk("arst/core_inicio", core_inicio, 0);
        chk("arst/core_x", core_x, 0);
        chk("arst/core_a", core_a, 0);
        req = '0;
        @(negedge ck);
        rst = 1'b1;
        req_x[2*W +: W] = 16'd2; req_a[2*W +: W] = 16'd3;
        req_b[2*W +: W] = 16'd5; req_c[2*W +: W] = 16'd7;
        req_x[3*W +: W] = 16'd3; req_a[3*W +: W] = 16'd2;
        req_b[3*W +: W] = 16'd0; req_c[3*W +: W] = 16'd1;
        req = 4'b1100;
        wait_done(d);
        chk("arst/first_done", d, 4'b0100);
        chk("arst/first_res", resultado, 16'd29);
        req = 4'b1000;
        wait_done(d);
        chk("arst/second_done", d, 4'b1000);
        chk("arst/second_res", resultado, 16'd19);
        req = '0;

        // stale pronto held between jobs must be masked
        hold_pronto = 1'b1;
        run_single(1, 16'd4, 16'd1, 16'd1, 16'd1, 16'd21, 1'b0, 1'b0, LAT, "stale_a");
        run_single(1, 16'd7, 16'd2, 16'd3, 16'd4, 16'd123, 1'b0, 1'b0, LAT, "stale_b");
        hold_pronto = 1'b0;
        repeat (3) @(negedge ck);

        // request dropped and operands changed right after grant
        run_single(0, 16'd9, 16'd2, 16'd0, 16'd3, 16'd165, 1'b0, 1'b0, LAT, "drop");

        repeat (3) @(negedge ck);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
